ifu: RTL

Instruction fetch unit for the single-cycle MIPS core. It holds the program counter and fetches each instruction word from instruction memory over a request/acknowledge handshake. It presents the word on `ins` to the control decoder. It takes back the decoder's `branch`/`jump` outputs and the ALU `zero` flag to compute the next PC.

---
 rtl/ifu.sv | 98 +++++++++
 1 files changed

// File: rtl/ifu.sv
// Instruction fetch unit for the single-cycle MIPS core: holds the PC, fetches
// each word over a req/ack handshake and resolves jump/branch redirects.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins,
    output logic        ins_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] icount
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC
    } stateT;

    stateT       state;
    stateT       nextState;
    logic        captureIns;
    logic        advancePc;
    logic [31:0] jumpTarget;
    logic [31:0] branchOffset;
    logic [31:0] branchTarget;
    logic [31:0] nextPc;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    assign captureIns = (state == FETCH) && imem_ack;
    assign advancePc  = (state == EXEC) && !stall;

    assign jumpTarget   = {pc_plus4[31:28], ins[25:0], 2'b00};
    assign branchOffset = {{14{ins[15]}}, ins[15:0], 2'b00};
    assign branchTarget = pc_plus4 + branchOffset;

    // Redirect priority: jump beats a taken branch, which beats sequential.
    always_comb begin
        nextPc = pc_plus4;
        if (jump) begin
            nextPc = jumpTarget;
        end else if (branch && zero) begin
            nextPc = branchTarget;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = FETCH;
            FETCH:   if (imem_ack) nextState = EXEC;
            EXEC:    if (!stall) nextState = FETCH;
            default: nextState = IDLE;
        endcase
    end

    // Handshake flags are registered copies of the upcoming state so they
    // line up exactly with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req  <= 1'b0;
            ins_valid <= 1'b0;
            ins       <= 32'h0000_0000;
            pc        <= RESET_PC;
            icount    <= 32'h0000_0000;
        end else begin
            imem_req  <= (nextState == FETCH);
            ins_valid <= (nextState == EXEC);
            if (captureIns) begin
                ins <= imem_rdata;
            end
            if (advancePc) begin
                pc     <= nextPc;
                icount <= icount + 32'd1;
            end
        end
    end

endmodule
